// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, ALUOp,
// mux selects and the main controller state type.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    // ALUOp is also decoded by the ALU control block, so keep these in sync
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

endpackage

// File: rtl/mips_main_ctrl.sv
// Multicycle MIPS main controller: sequences each instruction through its
// states and drives the datapath enables, mux selects and ALUOp.
module mips_main_ctrl
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal_op
);

    state_t state;
    state_t next_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PCSRC_ALU;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_B;
        alu_op     = ALUOP_ADD;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        illegal_op = 1'b0;

        unique case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) next_state = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMMSH;
                case (opcode)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_EXECUTE;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_ADDI:      next_state = S_ADDIEXEC;
                    OP_J:         next_state = S_JUMP;
                    default: begin
                        next_state = S_FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                if      (opcode == OP_LW) next_state = S_MEMRD;
                else if (opcode == OP_SW) next_state = S_MEMWR;
                else                      next_state = S_FETCH;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
                if (mem_ready) next_state = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                next_state = S_FETCH;
            end
            S_MEMWR: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) next_state = S_FETCH;
            end
            S_EXECUTE: begin
                alu_src_a  = 1'b1;
                alu_op     = ALUOP_FUNCT;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = ALUOP_SUB;
                pc_src     = PCSRC_ALUOUT;
                pc_write   = zero;
                next_state = S_FETCH;
            end
            S_ADDIEXEC: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                next_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write  = 1'b1;
                next_state = S_FETCH;
            end
            S_JUMP: begin
                pc_src     = PCSRC_JUMP;
                pc_write   = 1'b1;
                next_state = S_FETCH;
            end
            default: next_state = S_FETCH;
        endcase

        // Reset must silence the memory request immediately, not a cycle later
        if (!rst_n) begin
            mem_req    = 1'b0;
            mem_write  = 1'b0;
            i_or_d     = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            pc_src     = PCSRC_ALU;
            alu_src_a  = 1'b0;
            alu_src_b  = SRCB_B;
            alu_op     = ALUOP_ADD;
            reg_write  = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            illegal_op = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_main_ctrl.sv
// Directed bench for mips_main_ctrl: each cycle pushes the expected control
// word to a scoreboard queue and pops it for comparison at the falling edge.
module tb_mips_main_ctrl;

    localparam logic [5:0] LW   = 6'h23;
    localparam logic [5:0] SW   = 6'h2B;
    localparam logic [5:0] RT   = 6'h00;
    localparam logic [5:0] BEQ  = 6'h04;
    localparam logic [5:0] ADDI = 6'h08;
    localparam logic [5:0] JMP  = 6'h02;
    localparam logic [5:0] BAD  = 6'h3F;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_write, i_or_d, ir_write, pc_write;
    logic [1:0] pc_src, alu_src_b, alu_op;
    logic       alu_src_a, reg_write, reg_dst, mem_to_reg, illegal_op;
    logic [15:0] observed;

    typedef struct {
        logic [15:0] v;
        string       tag;
    } sb_entry_t;

    sb_entry_t sbq[$];
    int checkCount = 0;
    int failCount  = 0;

    mips_main_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .i_or_d     (i_or_d),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .illegal_op (illegal_op)
    );

    assign observed = {mem_req, mem_write, i_or_d, ir_write, pc_write, pc_src,
                       alu_src_a, alu_src_b, alu_op, reg_write, reg_dst,
                       mem_to_reg, illegal_op};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ctrl(
        input logic mreq, input logic mwr, input logic iod, input logic irw,
        input logic pcw, input logic [1:0] pcs, input logic a,
        input logic [1:0] b, input logic [1:0] aop, input logic rw,
        input logic rd, input logic m2r, input logic ill);
        return {mreq, mwr, iod, irw, pcw, pcs, a, b, aop, rw, rd, m2r, ill};
    endfunction

    // Expected control word for each state, written out from the state table
    function automatic logic [15:0] expFetch(input logic mr);
        return ctrl(1, 0, 0, mr, mr, 2'b00, 0, 2'b01, 2'b00, 0, 0, 0, 0);
    endfunction
    function automatic logic [15:0] expDecode(input logic ill);
        return ctrl(0, 0, 0, 0, 0, 2'b00, 0, 2'b11, 2'b00, 0, 0, 0, ill);
    endfunction
    function automatic logic [15:0] expMemAdr();
        return ctrl(0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 2'b00, 0, 0, 0, 0);
    endfunction
    function automatic logic [15:0] expMemRd();
        return ctrl(1, 0, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    endfunction
    function automatic logic [15:0] expMemWb();
        return ctrl(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 0, 1, 0);
    endfunction
    function automatic logic [15:0] expMemWr();
        return ctrl(1, 1, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    endfunction
    function automatic logic [15:0] expExecute();
        return ctrl(0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 2'b10, 0, 0, 0, 0);
    endfunction
    function automatic logic [15:0] expAluWb();
        return ctrl(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 1, 0, 0);
    endfunction
    function automatic logic [15:0] expBranch(input logic z);
        return ctrl(0, 0, 0, 0, z, 2'b01, 1, 2'b00, 2'b01, 0, 0, 0, 0);
    endfunction
    function automatic logic [15:0] expAddiExec();
        return ctrl(0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 2'b00, 0, 0, 0, 0);
    endfunction
    function automatic logic [15:0] expAddiWb();
        return ctrl(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 0, 0, 0);
    endfunction
    function automatic logic [15:0] expJump();
        return ctrl(0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    endfunction

    task automatic applyStimulus(input logic [5:0] op, input logic z,
                                 input logic mr, input logic [15:0] expv,
                                 input string tag);
        sb_entry_t e;
        opcode    = op;
        zero      = z;
        mem_ready = mr;
        e.v   = expv;
        e.tag = tag;
        sbq.push_back(e);
    endtask

    task automatic checkOutput();
        sb_entry_t e;
        checkCount++;
        if (sbq.size() == 0) begin
            failCount++;
            $display("[TB] FAIL scoreboard_empty observed=%h expected=none", observed);
        end else begin
            e = sbq.pop_front();
            assert (observed === e.v) else begin
                failCount++;
                $error("[TB] FAIL %s observed=%h expected=%h", e.tag, observed, e.v);
            end
        end
    endtask

    // One full cycle: drive just after the rising edge, compare at the falling edge
    task automatic runStep(input logic [5:0] op, input logic z, input logic mr,
                           input logic [15:0] expv, input string tag);
        applyStimulus(op, z, mr, expv, tag);
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        opcode    = 6'h00;
        zero      = 1'b0;
        mem_ready = 1'b0;

        @(posedge clk);
        #1;
        applyStimulus(LW, 1'b1, 1'b1, 16'h0000, "reset_hold");
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        runStep(LW, 0, 1, expFetch(1),  "lw_fetch");
        runStep(LW, 0, 1, expDecode(0), "lw_decode");
        runStep(LW, 0, 1, expMemAdr(),  "lw_memadr");
        runStep(LW, 0, 1, expMemRd(),   "lw_memrd");
        runStep(LW, 0, 1, expMemWb(),   "lw_memwb");

        // mem_ready low outside memory states must not stall the R-type path
        runStep(RT, 0, 1, expFetch(1),   "r_fetch");
        runStep(RT, 0, 0, expDecode(0),  "r_decode");
        runStep(RT, 0, 0, expExecute(),  "r_execute");
        runStep(RT, 0, 0, expAluWb(),    "r_aluwb");

        runStep(BEQ, 1, 1, expFetch(1),  "beq1_fetch");
        runStep(BEQ, 1, 1, expDecode(0), "beq1_decode");
        runStep(BEQ, 1, 1, expBranch(1), "beq1_branch");
        runStep(BEQ, 0, 1, expFetch(1),  "beq0_fetch");
        runStep(BEQ, 0, 1, expDecode(0), "beq0_decode");
        runStep(BEQ, 0, 1, expBranch(0), "beq0_branch");

        for (int i = 0; i < 3; i++)
            runStep(ADDI, 0, 0, expFetch(0), "stall_fetch");
        runStep(ADDI, 0, 1, expFetch(1),    "stall_fetch_done");
        runStep(ADDI, 0, 1, expDecode(0),   "addi_decode");
        runStep(ADDI, 0, 1, expAddiExec(),  "addi_exec");
        runStep(ADDI, 0, 1, expAddiWb(),    "addi_wb");

        runStep(SW, 0, 1, expFetch(1),  "sw_fetch");
        runStep(SW, 0, 1, expDecode(0), "sw_decode");
        runStep(SW, 0, 1, expMemAdr(),  "sw_memadr");
        runStep(SW, 0, 0, expMemWr(),   "sw_memwr_stall0");
        runStep(SW, 0, 0, expMemWr(),   "sw_memwr_stall1");
        runStep(SW, 0, 1, expMemWr(),   "sw_memwr_done");

        runStep(BAD, 0, 1, expFetch(1),  "ill_fetch");
        runStep(BAD, 0, 1, expDecode(1), "ill_decode");
        runStep(JMP, 0, 1, expFetch(1),  "j_fetch");
        runStep(JMP, 0, 1, expDecode(0), "j_decode");
        runStep(JMP, 0, 1, expJump(),    "j_jump");

        runStep(SW, 0, 1, expFetch(1),  "rsw_fetch");
        runStep(SW, 0, 1, expDecode(0), "rsw_decode");
        runStep(SW, 0, 1, expMemAdr(),  "rsw_memadr");
        applyStimulus(SW, 0, 0, expMemWr(), "rsw_memwr");
        #1;
        checkOutput();
        rst_n = 1'b0;
        applyStimulus(SW, 0, 1, 16'h0000, "rst_async");
        #1;
        checkOutput();
        applyStimulus(SW, 0, 1, 16'h0000, "rst_held");
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        runStep(LW, 0, 0, expFetch(0),  "post_rst_fetch");
        runStep(LW, 0, 1, expFetch(1),  "post_rst_fetch_done");
        runStep(LW, 0, 1, expDecode(0), "post_rst_decode");
        runStep(LW, 0, 1, expMemAdr(),  "post_rst_memadr");

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
